seven_seg_scan_driver: RTL and testbench

Time-multiplexed driver for an N-digit common-anode/cathode seven-segment display bank. It takes a packed hexadecimal value, decimal points and per-digit enables, and scans one digit at a time at a programmable refresh rate. Updates are tear-free and applied only at frame boundaries. Optional leading-zero blanking and inter-digit dead time are included. It sits between the CPU's debug/IO register and the board's segment and anode pins, and supersedes the purely combinational single-digit decoder.

---
 rtl/seven_seg_scan_driver_if.sv | 12 +
 rtl/seven_seg_scan_driver.sv | 85 ++++++++
 tb/tb_seven_seg_scan_driver.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_driver_if.sv
// seven_seg_scan_driver_if: host-side load bus (value, decimal points, enables, blanking, strobe)
interface seven_seg_scan_driver_if #(
   parameter int NUM_DIGITS = 8
);
   logic [4*NUM_DIGITS-1:0] value;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   digit_en;
   logic                    lz_blank;
   logic                    load;
   modport master (output value, dp_in, digit_en, lz_blank, load);
   modport slave  (input  value, dp_in, digit_en, lz_blank, load);
endinterface

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed N-digit seven-segment scanner with frame-synchronous commit
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS     = 8,
   parameter int REFRESH_DIV    = 100000,
   parameter int DEAD_CYCLES    = 16,
   parameter bit ACTIVE_LOW_SEG = 1'b1,
   parameter bit ACTIVE_LOW_AN  = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   seven_seg_scan_driver_if.slave bus,
   output logic [6:0]             seg,
   output logic                   dp,
   output logic [NUM_DIGITS-1:0]  an,
   output logic                   frame_done
);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam logic [6:0] SEG_OFF = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
   localparam logic [NUM_DIGITS-1:0] AN_OFF = ACTIVE_LOW_AN ? '1 : '0;
   localparam logic [6:0] GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic [CW-1:0]           cnt;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] p_val, d_val;
   logic [NUM_DIGITS-1:0]   p_dp, p_en, d_dp, d_en, blank, sel;
   logic                    p_lz, d_lz, z, slot_end, frame_end, cur_blank;
   logic [3:0]              nib;

   assign slot_end  = cnt == CW'(REFRESH_DIV - 1);
   assign frame_end = slot_end && idx == IW'(NUM_DIGITS - 1);
   assign nib       = d_val[{idx, 2'b00} +: 4];
   assign cur_blank = blank[idx];
   assign sel       = NUM_DIGITS'(1) << idx;

   // slot counter and digit index; the index wrap marks the frame end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else begin
         cnt <= slot_end ? '0 : cnt + 1'b1;
         idx <= frame_end ? '0 : slot_end ? idx + 1'b1 : idx;
      end

   // pending captures every load; display commits only at frame end, bypassing a coincident load
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         {p_val, p_dp, p_en, p_lz} <= '0;
         {d_val, d_dp, d_en, d_lz} <= '0;
      end else begin
         if (bus.load)
            {p_val, p_dp, p_en, p_lz} <= {bus.value, bus.dp_in, bus.digit_en, bus.lz_blank};
         if (frame_end)
            {d_val, d_dp, d_en, d_lz} <= bus.load ? {bus.value, bus.dp_in, bus.digit_en, bus.lz_blank}
                                                  : {p_val, p_dp, p_en, p_lz};
      end

   // per-digit blanking: disabled digits, plus zeros above the most significant non-zero nibble
   always_comb begin
      z     = 1'b1;
      blank = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         z        = z && d_val[4*i +: 4] == 4'd0;
         blank[i] = !d_en[i] || (d_lz && i > 0 && z);
      end
   end

   // registered pin drivers, polarity applied on the way out
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         seg        <= SEG_OFF;
         dp         <= ACTIVE_LOW_SEG;
         an         <= AN_OFF;
         frame_done <= 1'b0;
      end else begin
         seg        <= cur_blank ? SEG_OFF : GLYPH[nib] ^ SEG_OFF;
         dp         <= (!cur_blank && d_dp[idx]) ^ ACTIVE_LOW_SEG;
         an         <= (cur_blank || 32'(cnt) < DEAD_CYCLES) ? AN_OFF : sel ^ AN_OFF;
         frame_done <= frame_end;
      end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: scoreboard bench for the 4-digit, 4-cycle-slot, active-low configuration
module tb_seven_seg_scan_driver;
   typedef struct {
      int         cyc;
      int         ph;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;
   logic       frame_done;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         base = 0;
   exp_t       sb[$];
   exp_t       m;
   exp_t       left;

   seven_seg_scan_driver_if #(.NUM_DIGITS(4)) bus ();

   seven_seg_scan_driver #(
      .NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1),
      .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int c, input int ph, input logic [3:0] a, input logic [6:0] s,
                       input logic d, input logic f);
      exp_t e;
      e.cyc = c;
      e.ph  = ph;
      e.an  = a;
      e.seg = s;
      e.dp  = d;
      e.fd  = f;
      sb.push_back(e);
   endtask

   task automatic dark(input int c, input int ph);
      push(c, ph, 4'hF, 7'h7F, 1'b1, 1'b0);
   endtask

   // g = {glyph3, glyph2, glyph1, glyph0} active-high; c0 = first output cycle of the frame
   task automatic expect_frame(input int c0, input int n, input int ph, input logic [27:0] g,
                               input logic [3:0] blk, input logic [3:0] dpv);
      for (int i = 0; i < n; i++) begin
         int   s;
         logic b;
         s = i / 4;
         b = blk[s];
         push(c0 + i, ph, (b || i % 4 == 0) ? 4'hF : ~(4'b0001 << s),
              b ? 7'h7F : ~g[7*s +: 7], b | ~dpv[s], i == 15);
      end
   endtask

   task automatic at(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic do_load(input int k, input logic [15:0] v, input logic [3:0] en,
                          input logic [3:0] d, input logic lz);
      at(base + k);
      bus.value    = v;
      bus.digit_en = en;
      bus.dp_in    = d;
      bus.lz_blank = lz;
      bus.load     = 1'b1;
      at(base + k + 1);
      bus.load     = 1'b0;
   endtask

   initial forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         m = sb.pop_front();
         n_cmp++;
         if (m.cyc != cyc || an !== m.an || seg !== m.seg || dp !== m.dp || frame_done !== m.fd) begin
            n_bad++;
            $display("FAIL ph%0d cyc%0d (now %0d): got an=%h seg=%h dp=%b fd=%b, want an=%h seg=%h dp=%b fd=%b",
                     m.ph, m.cyc, cyc, an, seg, dp, frame_done, m.an, m.seg, m.dp, m.fd);
         end
      end
   end

   initial begin
      bus.value    = '0;
      bus.dp_in    = '0;
      bus.digit_en = '0;
      bus.lz_blank = 1'b0;
      bus.load     = 1'b0;
      #1 rst_n = 1'b0;
      dark(3, 0);
      at(4);
      rst_n = 1'b1;
      base  = 4;
      expect_frame(base + 1,   16, 1, '0, 4'hF, 4'h0);
      expect_frame(base + 17,  16, 1, '0, 4'hF, 4'h0);
      expect_frame(base + 33,  16, 2, {7'h06, 7'h5B, 7'h77, 7'h71}, 4'h0, 4'b0100);
      expect_frame(base + 49,  16, 3, {7'h00, 7'h00, 7'h4F, 7'h3F}, 4'b1100, 4'h0);
      expect_frame(base + 65,  16, 4, {4{7'h06}}, 4'h0, 4'h0);
      expect_frame(base + 81,  16, 4, {4{7'h5B}}, 4'h0, 4'h0);
      expect_frame(base + 97,  16, 5, {4{7'h07}}, 4'h0, 4'h0);
      expect_frame(base + 113, 16, 5, {4{7'h07}}, 4'h0, 4'h0);
      expect_frame(base + 129, 9,  6, {4{7'h07}}, 4'h0, 4'h0);
      for (int c = 138; c <= 141; c++) dark(base + c, 6);
      do_load(20, 16'h12AF, 4'hF, 4'b0100, 1'b0);
      do_load(40, 16'h0030, 4'hF, 4'h0, 1'b1);
      do_load(56, 16'h1111, 4'hF, 4'h0, 1'b0);
      do_load(72, 16'h2222, 4'hF, 4'h0, 1'b0);
      do_load(85, 16'h5555, 4'hF, 4'h0, 1'b0);
      do_load(95, 16'h7777, 4'hF, 4'h0, 1'b0);
      at(base + 137);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_cmp += 4;
      if (an !== 4'hF) begin
         n_bad++;
         $display("FAIL async reset: an=%h", an);
      end
      if (seg !== 7'h7F) begin
         n_bad++;
         $display("FAIL async reset: seg=%h", seg);
      end
      if (dp !== 1'b1) begin
         n_bad++;
         $display("FAIL async reset: dp=%b", dp);
      end
      if (frame_done !== 1'b0) begin
         n_bad++;
         $display("FAIL async reset: frame_done=%b", frame_done);
      end
      at(base + 142);
      rst_n = 1'b1;
      base  = base + 142;
      expect_frame(base + 1,  16, 7, '0, 4'hF, 4'h0);
      expect_frame(base + 17, 16, 7, '0, 4'hF, 4'h0);
      expect_frame(base + 33, 16, 7, {7'h66, 7'h4F, 7'h5B, 7'h06}, 4'h0, 4'h0);
      do_load(20, 16'h4321, 4'hF, 4'h0, 1'b0);
      for (int i = 0; i < 64 && sb.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      while (sb.size() > 0) begin
         left = sb.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL ph%0d cyc%0d: expectation never compared", left.ph, left.cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
